// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start bit, 2-bit port, 4-bit length (MSB first), then
// the payload LSB first, one bit per clk_en step. The line idles high.
module serial_frame_tx #(
    parameter int MAX_LEN = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_en,
    input  logic        start,
    input  logic [1:0]  port,
    input  logic [3:0]  len,
    input  logic [15:0] data,
    output logic        ser_out,
    output logic        busy,
    output logic        done,
    output logic [4:0]  bits_left,
    output logic [2:0]  state_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_PORT  = 3'd2,
        S_LEN   = 3'd3,
        S_DATA  = 3'd4,
        S_FIN   = 3'd5
    } state_t;

    localparam logic [3:0] LEN_CAP = 4'(MAX_LEN);

    state_t      state_q, state_d;
    logic [1:0]  port_q, port_d;
    logic [3:0]  len_q, len_d;
    logic [15:0] shreg_q, shreg_d;
    logic [2:0]  hdr_cnt_q, hdr_cnt_d;
    logic [4:0]  bits_left_q, bits_left_d;
    logic [3:0]  len_acc;

    // Requests longer than the configured maximum are clipped rather than overrun.
    assign len_acc = (len > LEN_CAP) ? LEN_CAP : len;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            port_q      <= '0;
            len_q       <= '0;
            shreg_q     <= '0;
            hdr_cnt_q   <= '0;
            bits_left_q <= '0;
        end else begin
            state_q     <= state_d;
            port_q      <= port_d;
            len_q       <= len_d;
            shreg_q     <= shreg_d;
            hdr_cnt_q   <= hdr_cnt_d;
            bits_left_q <= bits_left_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        port_d      = port_q;
        len_d       = len_q;
        shreg_d     = shreg_q;
        hdr_cnt_d   = hdr_cnt_q;
        bits_left_d = bits_left_q;
        case (state_q)
            S_IDLE: begin
                // A clk_en coinciding with acceptance is deliberately not consumed here.
                if (start) begin
                    state_d     = S_START;
                    port_d      = port;
                    len_d       = len_acc;
                    shreg_d     = data;
                    hdr_cnt_d   = 3'd0;
                    bits_left_d = {1'b0, len_acc};
                end
            end
            S_START: begin
                if (clk_en) begin
                    state_d   = S_PORT;
                    hdr_cnt_d = 3'd1;
                end
            end
            S_PORT: begin
                if (clk_en) begin
                    if (hdr_cnt_q == 3'd2) begin
                        state_d   = S_LEN;
                        hdr_cnt_d = 3'd1;
                    end else begin
                        hdr_cnt_d = hdr_cnt_q + 3'd1;
                    end
                end
            end
            S_LEN: begin
                if (clk_en) begin
                    if (hdr_cnt_q == 3'd4) begin
                        hdr_cnt_d = 3'd0;
                        state_d   = (len_q != 4'd0) ? S_DATA : S_FIN;
                    end else begin
                        hdr_cnt_d = hdr_cnt_q + 3'd1;
                    end
                end
            end
            S_DATA: begin
                if (clk_en) begin
                    shreg_d = {1'b0, shreg_q[15:1]};
                    if (bits_left_q != 5'd0) begin
                        bits_left_d = bits_left_q - 5'd1;
                    end
                    if (bits_left_q <= 5'd1) begin
                        state_d = S_FIN;
                    end
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ser_out   = 1'b1;
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_FIN);
        bits_left = (state_q == S_IDLE) ? 5'd0 : bits_left_q;
        case (state_q)
            S_START: ser_out = 1'b0;
            S_PORT:  ser_out = (hdr_cnt_q == 3'd1) ? port_q[1] : port_q[0];
            S_LEN: begin
                case (hdr_cnt_q)
                    3'd1:    ser_out = len_q[3];
                    3'd2:    ser_out = len_q[2];
                    3'd3:    ser_out = len_q[1];
                    default: ser_out = len_q[0];
                endcase
            end
            S_DATA:  ser_out = shreg_q[0];
            default: ser_out = 1'b1;
        endcase
    end

    assign state_o = state_q;

endmodule
